mac_job_sequencer: RTL and testbench
====================================

// Module: mac_job_sequencer
// PURPOSE
// Sequences a pipelined signed multiply-accumulate slice built from pipeline_reg stages (input A/B regs, M reg, P accumulator).
// Accepts a job of LEN operand pairs over valid/ready, gates the per-stage clock enables, and drains the pipeline.
// Presents the accumulated result with a valid/ready handshake. Sits between the stream front-end and result consumer.
// PARAMETERS
// A_WIDTH   18  signed operand A width
// B_WIDTH   18  signed operand B width
// P_WIDTH   48  accumulator/result width; must be >= A_WIDTH+B_WIDTH
// AREG      1   input register stage present (0/1)
// MREG      1   multiplier output register stage present (0/1)
// LEN_W     8   width of job length field
// PORTS
// CLK          in   1        clock; all logic on rising edge
// RST          in   1        synchronous, active-high reset
// start_valid  in   1        job request
// start_ready  out  1        high only in IDLE
// len          in   LEN_W    operand pairs in job, sampled on start accept; 0 allowed
// op_valid     in   1        operand pair valid
// op_ready     out  1        high only in LOAD
// A            in   A_WIDTH  signed operand
// B            in   B_WIDTH  signed operand
// res_valid    out  1        result valid (DONE state)
// res_ready    in   1        consumer accepts result
// P            out  P_WIDTH  signed accumulated result
// overflow     out  1        sticky signed-overflow flag for current job
// ce_in,ce_m,ce_p out 1 each stage clock enables exported to pipeline_reg instances
// rst_p        out  1        one-cycle accumulator clear pulse
// BEHAVIOUR
// - Reset (RST=1 at edge): state IDLE; P=0, overflow=0, res_valid=0, op_ready=0, start_ready=1, all ce_*=0, rst_p=0,
//   stage valid tags and counters cleared. Applies from any state, incl. mid-LOAD/DRAIN; in-flight job discarded.
// - FSM IDLE->LOAD->DRAIN->DONE->IDLE. D = AREG+MREG.
// - IDLE: on start_valid: latch len, pulse rst_p, clear P and overflow; next LOAD (len>0) or DONE (len==0).
// - LOAD: each accept (op_valid&op_ready) advances the whole pipeline: ce_in/ce_m/ce_p=1 that cycle only;
//   no accept -> all ce_*=0, pipeline frozen, no accumulation. After len-th accept: DRAIN if D>0, else DONE.
// - DRAIN: all ce_*=1 every cycle, op_ready=0; stage tags shift in 0; exactly D cycles, then DONE.
// - Accumulate: P <= P + sext(A_d*B_d) only when P-stage tag valid and ce_p=1. Product A_WIDTH+B_WIDTH signed,
//   sign-extended to P_WIDTH; sum wraps two's-complement; overflow set (sticky) on signed add overflow.
// - Latency: res_valid high in cycle after edge k+D, where edge k accepts last operand (D=0: cycle after edge k).
// - DONE: res_valid=1, P and overflow held stable; start_valid ignored; res_valid&res_ready -> IDLE;
//   start_ready rises next cycle (no same-cycle restart). P keeps last result in IDLE until next start.
// - len==0: res_valid in cycle after start accept, P=0, overflow=0.
// - op_valid in IDLE/DRAIN/DONE ignored; operand data never sampled without accept.
// TESTING
// 1 RST held 2 cycles mid-LOAD -> start_ready=1, op_ready=0, res_valid=0, P=0, overflow=0, ce_*=0.
// 2 AREG=MREG=1, len=3, A={2,-3,4}, B={5,6,-7} back-to-back -> res_valid 2 edges after last accept, P=-36, overflow=0.
// 3 Same job with op_valid low 2 cycles between pairs -> ce_*=0 in gaps, P=-36, same post-last-accept latency.
// 4 len=0 -> res_valid next cycle, P=0; AREG=MREG=0 len=1 A=3 B=4 -> res_valid cycle after accept, P=12.
// 5 res_ready low 5 cycles in DONE with start_valid=1 -> P, res_valid stable, start_ready=0; release -> start_ready next cycle.
// 6 A_WIDTH=B_WIDTH=8, P_WIDTH=16, len=2, A=B=-128 -> P=-32768 (wrapped), overflow=1; next job clears overflow.

Source files
------------

// File: rtl/mac_job_sequencer.sv
// Job sequencer and datapath for a pipelined signed MAC slice: accepts LEN operand pairs,
// gates the per-stage enables, drains the pipeline and presents the accumulated result.
module mac_job_sequencer #(
    parameter int unsigned A_WIDTH = 18,
    parameter int unsigned B_WIDTH = 18,
    parameter int unsigned P_WIDTH = 48,
    parameter int unsigned AREG    = 1,
    parameter int unsigned MREG    = 1,
    parameter int unsigned LEN_W   = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [LEN_W-1:0]           len,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic signed [A_WIDTH-1:0]  A,
    input  logic signed [B_WIDTH-1:0]  B,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [P_WIDTH-1:0]  P,
    output logic                       overflow,
    output logic                       ce_in,
    output logic                       ce_m,
    output logic                       ce_p,
    output logic                       rst_p
);

    localparam int unsigned PR_W       = A_WIDTH + B_WIDTH;
    localparam int unsigned D          = AREG + MREG;
    localparam bit          HAS_PIPE   = (D != 0);
    localparam logic [1:0]  DRAIN_LAST = (D == 0) ? 2'd0 : 2'(D - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [LEN_W-1:0]           r_cnt;
    logic [1:0]                 r_dcnt;
    logic signed [P_WIDTH-1:0]  r_p;
    logic                       r_ovf;
    logic                       w_acc;
    logic                       w_start;

    logic signed [A_WIDTH-1:0]  w_a_d;
    logic signed [B_WIDTH-1:0]  w_b_d;
    logic                       w_ta;
    logic signed [PR_W-1:0]     w_a_x;
    logic signed [PR_W-1:0]     w_b_x;
    logic signed [PR_W-1:0]     w_prod;
    logic signed [PR_W-1:0]     w_m_d;
    logic                       w_tm;
    logic signed [P_WIDTH-1:0]  w_m_x;
    logic signed [P_WIDTH-1:0]  w_sum;
    logic                       w_add_ovf;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state, handshakes and stage enables
    always_comb begin
        w_next      = r_state;
        start_ready = 1'b0;
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        ce_in       = 1'b0;
        ce_m        = 1'b0;
        ce_p        = 1'b0;
        rst_p       = 1'b0;
        w_acc       = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_start = 1'b1;
                    rst_p   = 1'b1;
                    w_next  = (len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_acc = 1'b1;
                    ce_in = 1'b1;
                    ce_m  = 1'b1;
                    ce_p  = 1'b1;
                    if (r_cnt == LEN_W'(1)) w_next = HAS_PIPE ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                ce_in = 1'b1;
                ce_m  = 1'b1;
                ce_p  = 1'b1;
                if (r_dcnt == DRAIN_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= '0;
            r_dcnt <= '0;
        end else begin
            if (w_start)    r_cnt <= len;
            else if (w_acc) r_cnt <= r_cnt - LEN_W'(1);
            if (r_state == S_DRAIN) r_dcnt <= r_dcnt + 2'd1;
            else                    r_dcnt <= '0;
        end
    end

    // Input register stage; data only captured on an accepted pair
    if (AREG != 0) begin : g_areg
        logic signed [A_WIDTH-1:0] r_a;
        logic signed [B_WIDTH-1:0] r_b;
        logic                      r_ta;
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_a  <= '0;
                r_b  <= '0;
                r_ta <= 1'b0;
            end else begin
                if (ce_in) r_ta <= w_acc;
                if (w_acc) begin
                    r_a <= A;
                    r_b <= B;
                end
            end
        end
        assign w_a_d = r_a;
        assign w_b_d = r_b;
        assign w_ta  = r_ta;
    end else begin : g_no_areg
        assign w_a_d = A;
        assign w_b_d = B;
        assign w_ta  = w_acc;
    end

    assign w_a_x  = PR_W'(w_a_d);
    assign w_b_x  = PR_W'(w_b_d);
    assign w_prod = w_a_x * w_b_x;

    if (MREG != 0) begin : g_mreg
        logic signed [PR_W-1:0] r_m;
        logic                   r_tm;
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_m  <= '0;
                r_tm <= 1'b0;
            end else if (ce_m) begin
                r_tm <= w_ta;
                if (w_ta) r_m <= w_prod;
            end
        end
        assign w_m_d = r_m;
        assign w_tm  = r_tm;
    end else begin : g_no_mreg
        assign w_m_d = w_prod;
        assign w_tm  = w_ta;
    end

    assign w_m_x     = P_WIDTH'(w_m_d);
    assign w_sum     = r_p + w_m_x;
    assign w_add_ovf = (r_p[P_WIDTH-1] == w_m_x[P_WIDTH-1]) && (w_sum[P_WIDTH-1] != r_p[P_WIDTH-1]);

    // Wrapping accumulator with sticky signed-overflow flag
    always_ff @(posedge CLK) begin
        if (RST || w_start) begin
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else if (ce_p && w_tm) begin
            r_p <= w_sum;
            if (w_add_ovf) r_ovf <= 1'b1;
        end
    end

    assign P        = r_p;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Randomized bench: three sequencer configurations run in lockstep on shared controls,
// each checked against an arithmetic model of the job's wrapped sum and overflow.
module tb_mac_job_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start_valid;
    logic [7:0]  len_drv;
    logic        op_valid;
    logic [17:0] a_drv;
    logic [17:0] b_drv;
    logic        res_ready;

    logic        sr0, or0, rv0, ov0, ci0, cm0, cp0, rp0;
    logic signed [47:0] p0;
    logic        sr1, or1, rv1, ov1, ci1, cm1, cp1, rp1;
    logic signed [47:0] p1;
    logic        sr2, or2, rv2, ov2, ci2, cm2, cp2, rp2;
    logic signed [15:0] p2;

    int n_checks = 0;
    int n_errors = 0;
    int qa[$];
    int qb[$];

    always #5 CLK = ~CLK;

    mac_job_sequencer #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .AREG(1), .MREG(1), .LEN_W(8)) u_dut0 (
        .CLK(CLK), .RST(RST), .start_valid(start_valid), .start_ready(sr0), .len(len_drv),
        .op_valid(op_valid), .op_ready(or0), .A(a_drv), .B(b_drv), .res_valid(rv0), .res_ready(res_ready),
        .P(p0), .overflow(ov0), .ce_in(ci0), .ce_m(cm0), .ce_p(cp0), .rst_p(rp0));

    mac_job_sequencer #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .AREG(0), .MREG(0), .LEN_W(8)) u_dut1 (
        .CLK(CLK), .RST(RST), .start_valid(start_valid), .start_ready(sr1), .len(len_drv),
        .op_valid(op_valid), .op_ready(or1), .A(a_drv), .B(b_drv), .res_valid(rv1), .res_ready(res_ready),
        .P(p1), .overflow(ov1), .ce_in(ci1), .ce_m(cm1), .ce_p(cp1), .rst_p(rp1));

    mac_job_sequencer #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(16), .AREG(1), .MREG(1), .LEN_W(8)) u_dut2 (
        .CLK(CLK), .RST(RST), .start_valid(start_valid), .start_ready(sr2), .len(len_drv),
        .op_valid(op_valid), .op_ready(or2), .A(a_drv[7:0]), .B(b_drv[7:0]), .res_valid(rv2), .res_ready(res_ready),
        .P(p2), .overflow(ov2), .ce_in(ci2), .ce_m(cm2), .ce_p(cp2), .rst_p(rp2));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic longint sext(input longint v, input int w);
        longint x;
        x = v & ((longint'(1) << w) - 1);
        if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
        return x;
    endfunction

    // Exact signed sum, flagging any step that leaves the pw-bit range, then wrapping
    task automatic model(input int aw, input int pw, output longint p, output bit ovf);
        longint acc = 0;
        longint s;
        ovf = 1'b0;
        foreach (qa[i]) begin
            s = acc + sext(longint'(qa[i]), aw) * sext(longint'(qb[i]), aw);
            if (s != sext(s, pw)) ovf = 1'b1;
            acc = sext(s, pw);
        end
        p = acc;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start_ready0"}, sr0, 1);
        check({tag, "_op_ready0"}, or0, 0);
        check({tag, "_res_valid0"}, rv0, 0);
        check({tag, "_ce0"}, {ci0, cm0, cp0, rp0}, 0);
        check({tag, "_P0"}, p0, 0);
        check({tag, "_P1"}, p1, 0);
        check({tag, "_ovf1"}, ov1, 0);
        check({tag, "_P2"}, p2, 0);
        check({tag, "_start_ready2"}, sr2, 1);
    endtask

    task automatic run_job(input int gap, input int hold);
        int     n;
        int     g;
        int     lat0 = -1;
        int     lat1 = -1;
        int     lat2 = -1;
        int     exp_lat;
        longint ep0, ep1, ep2;
        bit     eo0, eo1, eo2;
        n = qa.size();
        model(18, 48, ep0, eo0);
        model(18, 48, ep1, eo1);
        model(8, 16, ep2, eo2);
        exp_lat = (n == 0) ? 0 : 2;

        start_valid = 1'b1;
        len_drv     = 8'(n);
        #1;
        check("start_ready", sr0, 1);
        check("rst_p", rp0, 1);
        tick();
        start_valid = 1'b0;

        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                op_valid = 1'b0;
                a_drv    = 18'($urandom);
                b_drv    = 18'($urandom);
                #1;
                check("gap_ce0", {ci0, cm0, cp0}, 0);
                check("gap_op_ready1", or1, 1);
                tick();
            end
            op_valid = 1'b1;
            a_drv    = 18'(qa[i]);
            b_drv    = 18'(qb[i]);
            #1;
            check("accept_ce0", {ci0, cm0, cp0}, 3'b111);
            tick();
        end

        // Junk on the operand port after the last accept must be ignored
        for (int idx = 0; idx < 8; idx++) begin
            op_valid = 1'($urandom);
            a_drv    = 18'($urandom);
            b_drv    = 18'($urandom);
            #1;
            if (rv0 && lat0 < 0) lat0 = idx;
            if (rv1 && lat1 < 0) lat1 = idx;
            if (rv2 && lat2 < 0) lat2 = idx;
            if (lat0 >= 0 && lat1 >= 0 && lat2 >= 0) break;
            tick();
        end
        op_valid = 1'b0;
        check("latency0", lat0, exp_lat);
        check("latency1", lat1, 0);
        check("latency2", lat2, exp_lat);
        check("P0", p0, ep0);
        check("ovf0", ov0, eo0);
        check("P1", p1, ep1);
        check("ovf1", ov1, eo1);
        check("P2", p2, ep2);
        check("ovf2", ov2, eo2);

        repeat (hold) begin
            start_valid = 1'b1;
            res_ready   = 1'b0;
            tick();
            check("hold_res_valid0", rv0, 1);
            check("hold_start_ready0", sr0, 0);
            check("hold_P0", p0, ep0);
            check("hold_P2", p2, ep2);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        #1;
        check("release_start_ready0", sr0, 0);
        tick();
        res_ready = 1'b0;
        check("post_start_ready0", sr0, 1);
        check("post_start_ready1", sr1, 1);
        check("post_start_ready2", sr2, 1);
        check("post_res_valid0", rv0, 0);
        check("post_P0", p0, ep0);
        check("post_P2", p2, ep2);
    endtask

    task automatic set_ops(input int n, input int av[6], input int bv[6]);
        qa.delete();
        qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(av[i]);
            qb.push_back(bv[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        RST         = 1'b1;
        start_valid = 1'b0;
        len_drv     = '0;
        op_valid    = 1'b0;
        a_drv       = '0;
        b_drv       = '0;
        res_ready   = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        check_idle_outputs("reset");

        set_ops(3, '{2, -3, 4, 0, 0, 0}, '{5, 6, -7, 0, 0, 0});
        run_job(0, 0);
        run_job(2, 0);
        set_ops(0, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});
        run_job(0, 1);
        set_ops(1, '{3, 0, 0, 0, 0, 0}, '{4, 0, 0, 0, 0, 0});
        run_job(0, 5);
        set_ops(2, '{-128, -128, 0, 0, 0, 0}, '{-128, -128, 0, 0, 0, 0});
        run_job(0, 0);
        set_ops(1, '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0});
        run_job(0, 0);

        for (int j = 0; j < 40; j++) begin
            int n;
            n = int'($urandom_range(0, 6));
            qa.delete();
            qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back(int'($urandom_range(0, 262143)));
                qb.push_back(int'($urandom_range(0, 262143)));
            end
            run_job(-1, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a job after a partial accumulation
        start_valid = 1'b1;
        len_drv     = 8'd5;
        tick();
        start_valid = 1'b0;
        op_valid    = 1'b1;
        a_drv       = 18'd3;
        b_drv       = 18'd4;
        tick();
        op_valid = 1'b0;
        check("midload_P1", p1, 12);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check_idle_outputs("midload_reset");

        set_ops(3, '{7, -1, 100, 0, 0, 0}, '{-9, -1, 100, 0, 0, 0});
        run_job(1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
